// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts a block, pulses the datapath load, steps 16 Feistel rounds
// with the key-rotate schedule for the captured mode, optionally runs a final-permutation cycle.
module des_round_ctrl #(
  parameter bit FP_STAGE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       decrypt_i,
  input  logic       abort_i,
  output logic       load_en_o,
  output logic       round_en_o,
  output logic [3:0] round_idx_o,
  output logic       shift_dir_o,
  output logic [1:0] shift_amt_o,
  output logic       last_round_o,
  output logic       fp_en_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // An abort drops the block before any fp_en or out_valid can be produced for it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    load_en_o   = 1'b0;
    round_en_o  = 1'b0;
    fp_en_o     = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!abort_i && in_valid_i) begin
          state_d = LOAD;
          mode_d  = decrypt_i;
        end
      end
      LOAD: begin
        load_en_o = 1'b1;
        cnt_d     = 4'd0;
        state_d   = abort_i ? IDLE : ROUND;
      end
      ROUND: begin
        round_en_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = FP_STAGE ? FINAL : DONE;
            fp_en_o = !FP_STAGE;
          end
        end
      end
      FINAL: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          fp_en_o = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o   = rst_n_i && (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign round_idx_o  = cnt_q;
  assign last_round_o = round_en_o && (cnt_q == 4'd15);

  // Decrypt skips the rotate on round 0 and rotates right to undo the encrypt schedule.
  always_comb begin
    shift_dir_o = 1'b0;
    shift_amt_o = 2'd0;
    if (round_en_o) begin
      shift_dir_o = mode_q;
      case (cnt_q)
        4'd0:                 shift_amt_o = mode_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15:    shift_amt_o = 2'd1;
        default:              shift_amt_o = 2'd2;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: one instance per FP_STAGE setting, both driven by the same
// stimulus and each compared every cycle against a block-age reference model.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rstN;
  logic inValid, decrypt, abort, outReady;

  logic       aInReady, aLoadEn, aRoundEn, aShiftDir, aLastRound, aFpEn, aOutValid, aBusy;
  logic [3:0] aRoundIdx;
  logic [1:0] aShiftAmt;
  logic       bInReady, bLoadEn, bRoundEn, bShiftDir, bLastRound, bFpEn, bOutValid, bBusy;
  logic [3:0] bRoundIdx;
  logic [1:0] bShiftAmt;

  always #5 clk = ~clk;

  des_round_ctrl #(.FP_STAGE(1'b1)) dutA (
    .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(aInReady),
    .decrypt_i(decrypt), .abort_i(abort), .load_en_o(aLoadEn), .round_en_o(aRoundEn),
    .round_idx_o(aRoundIdx), .shift_dir_o(aShiftDir), .shift_amt_o(aShiftAmt),
    .last_round_o(aLastRound), .fp_en_o(aFpEn), .out_valid_o(aOutValid),
    .out_ready_i(outReady), .busy_o(aBusy)
  );

  des_round_ctrl #(.FP_STAGE(1'b0)) dutB (
    .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(bInReady),
    .decrypt_i(decrypt), .abort_i(abort), .load_en_o(bLoadEn), .round_en_o(bRoundEn),
    .round_idx_o(bRoundIdx), .shift_dir_o(bShiftDir), .shift_amt_o(bShiftAmt),
    .last_round_o(bLastRound), .fp_en_o(bFpEn), .out_valid_o(bOutValid),
    .out_ready_i(outReady), .busy_o(bBusy)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model: a block is described only by its age in cycles since accept.
  logic [1:0] encSched [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] decSched [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  int   fpOf   [2] = '{1, 0};
  logic mIdle  [2];
  int   mAge   [2];
  logic mMode  [2];
  int   sumAmt [2];

  logic [13:0] snapA, snapB;
  logic [13:0] histA [32];
  logic [13:0] histB [32];

  typedef struct {
    int         cyc;
    logic [4:0] expA;
    logic [4:0] expB;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [13:0] packA();
    return {aInReady, aBusy, aLoadEn, aRoundEn, aRoundIdx, aShiftDir, aShiftAmt,
            aLastRound, aFpEn, aOutValid};
  endfunction

  function automatic logic [13:0] packB();
    return {bInReady, bBusy, bLoadEn, bRoundEn, bRoundIdx, bShiftDir, bShiftAmt,
            bLastRound, bFpEn, bOutValid};
  endfunction

  function automatic logic [4:0] strobes(input logic [13:0] s);
    return {s[13], s[11], s[10], s[1], s[0]};
  endfunction

  function automatic logic [13:0] modelOut(input int d);
    logic       ir, bz, ld, rn, dir, last, fp, ov;
    logic [3:0] ix;
    logic [1:0] amt;
    ir = 0; bz = 0; ld = 0; rn = 0; dir = 0; last = 0; fp = 0; ov = 0;
    ix = 4'd0; amt = 2'd0;
    if (mIdle[d]) begin
      ir = 1'b1;
    end else begin
      bz = 1'b1;
      if (mAge[d] == 1) begin
        ld = 1'b1;
      end else if (mAge[d] <= 17) begin
        rn   = 1'b1;
        ix   = 4'(mAge[d] - 2);
        dir  = mMode[d];
        amt  = mMode[d] ? decSched[ix] : encSched[ix];
        last = (ix == 4'd15);
        fp   = (fpOf[d] == 0) && (ix == 4'd15) && !abort;
      end else if (fpOf[d] == 1 && mAge[d] == 18) begin
        fp = !abort;
      end else begin
        ov = 1'b1;
      end
    end
    return {ir, bz, ld, rn, ix, dir, amt, last, fp, ov};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelStep(input int d);
    if (mIdle[d]) begin
      if (!abort && inValid) begin
        mIdle[d]  = 1'b0;
        mAge[d]   = 1;
        mMode[d]  = decrypt;
        sumAmt[d] = 0;
      end
    end else if (mAge[d] >= 18 + fpOf[d]) begin
      if (outReady) mIdle[d] = 1'b1;
    end else if (abort) begin
      mIdle[d] = 1'b1;
    end else begin
      if (mAge[d] == 17)
        checkOutput($sformatf("shift sum dut%0d", d), sumAmt[d], mMode[d] ? 27 : 28);
      mAge[d]++;
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mIdle[d]  = 1'b1;
      mAge[d]   = 0;
      sumAmt[d] = 0;
    end
  endtask

  // Drives one cycle of inputs, compares both instances mid-cycle, then advances the model.
  task automatic applyStimulus(input logic v, input logic dec, input logic ab, input logic rdy);
    inValid  = v;
    decrypt  = dec;
    abort    = ab;
    outReady = rdy;
    @(negedge clk);
    snapA = packA();
    snapB = packB();
    if (cycle < 32) begin
      histA[cycle] = snapA;
      histB[cycle] = snapB;
    end
    checkOutput($sformatf("fp1 cyc%0d", cycle), int'(snapA), int'(modelOut(0)));
    checkOutput($sformatf("fp0 cyc%0d", cycle), int'(snapB), int'(modelOut(1)));
    if (aRoundEn) sumAmt[0] += int'(aShiftAmt);
    if (bRoundEn) sumAmt[1] += int'(bShiftAmt);
    modelStep(0);
    modelStep(1);
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int held;
    int found;
    int seen;

    // {in_ready, load_en, round_en, fp_en, out_valid} at chosen cycles of one encrypt block.
    vecs[0] = '{cyc: 0,  expA: 5'b10000, expB: 5'b10000};
    vecs[1] = '{cyc: 1,  expA: 5'b01000, expB: 5'b01000};
    vecs[2] = '{cyc: 2,  expA: 5'b00100, expB: 5'b00100};
    vecs[3] = '{cyc: 10, expA: 5'b00100, expB: 5'b00100};
    vecs[4] = '{cyc: 17, expA: 5'b00100, expB: 5'b00110};
    vecs[5] = '{cyc: 18, expA: 5'b00010, expB: 5'b00001};
    vecs[6] = '{cyc: 19, expA: 5'b00001, expB: 5'b10000};
    vecs[7] = '{cyc: 20, expA: 5'b10000, expB: 5'b10000};

    rstN = 1'b0; inValid = 1'b0; decrypt = 1'b0; abort = 1'b0; outReady = 1'b0;
    modelReset();
    #3;
    checkOutput("reset fp1 outputs", int'(packA()), 0);
    checkOutput("reset fp0 outputs", int'(packB()), 0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    #1;
    checkOutput("in_ready after release", int'(aInReady), 1);
    @(posedge clk);
    #1;

    $display("[TB] encrypt latency table");
    cycle = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c < 22; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    foreach (vecs[i]) begin
      checkOutput($sformatf("vec fp1 cyc%0d", vecs[i].cyc), int'(strobes(histA[vecs[i].cyc])), int'(vecs[i].expA));
      checkOutput($sformatf("vec fp0 cyc%0d", vecs[i].cyc), int'(strobes(histB[vecs[i].cyc])), int'(vecs[i].expB));
    end

    $display("[TB] decrypt schedule");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 16; r++) begin
      checkOutput($sformatf("dec amt r%0d", r), int'({aShiftDir, aShiftAmt}), int'({1'b1, decSched[r]}));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    drain(4);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    held = 0;
    for (int i = 0; i < 40 && held < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (snapA[0]) held++;
    end
    checkOutput("out_valid held cycles", held, 5);
    checkOutput("in_ready while held", int'(aInReady), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("accept after handshake", int'(aLoadEn), 1);
    drain(22);

    $display("[TB] abort at round 7");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (aRoundEn && aRoundIdx == 4'd7) found = 1;
      else applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("reached round 7", found, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("idle after abort", int'({aBusy, aRoundIdx}), 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (snapA[0] || snapA[1] || snapB[0] || snapB[1]) seen++;
    end
    checkOutput("no result after abort", seen, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    drain(22);

    $display("[TB] reset at round 10");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (aRoundEn && aRoundIdx == 4'd10) found = 1;
      else applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("reached round 10", found, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset fp1", int'(packA()), 0);
    checkOutput("async reset fp0", int'(packB()), 0);
    modelReset();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart at round 0", int'({aRoundEn, aRoundIdx}), int'({1'b1, 4'd0}));
    drain(22);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
